// File: rtl/cache_pkg.sv
// Shared types and default geometry for the direct-mapped write-through cache controller.
package cache_pkg;

    localparam int unsigned CACHE_TAG_W     = 3;
    localparam int unsigned CACHE_INDEX_W   = 5;
    localparam int unsigned CACHE_OFFSET_W  = 2;
    localparam int unsigned WORDS_PER_BLOCK = 4;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_COMPARE   = 3'd1;
    localparam state_t ST_REFILL    = 3'd2;
    localparam state_t ST_WRITE_MEM = 3'd3;
    localparam state_t ST_RESPOND   = 3'd4;

endpackage

// File: rtl/cache_ctrl_fsm.sv
// Control FSM for a direct-mapped, write-through, write-no-allocate data cache:
// tag compare, block refill and write-through sequencing over a ready handshake.
module cache_ctrl_fsm
    import cache_pkg::*;
#(
    parameter int unsigned TAG_W    = CACHE_TAG_W,
    parameter int unsigned INDEX_W  = CACHE_INDEX_W,
    parameter int unsigned OFFSET_W = CACHE_OFFSET_W
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              i_mem_read,
    input  logic                              i_mem_write,
    input  logic [TAG_W+INDEX_W+OFFSET_W-1:0] i_address,
    input  logic [TAG_W-1:0]                  i_tag_in,
    input  logic                              i_valid_in,
    input  logic                              i_mem_ready,
    output logic [INDEX_W-1:0]                o_sel_index,
    output logic [OFFSET_W-1:0]               o_word_sel,
    output logic                              o_stall,
    output logic                              o_done,
    output logic                              o_hit,
    output logic                              o_cache_we,
    output logic                              o_refill_we,
    output logic                              o_tag_we,
    output logic                              o_mem_rd,
    output logic                              o_mem_wr
);

    localparam int unsigned ADDR_W = TAG_W + INDEX_W + OFFSET_W;
    localparam logic [OFFSET_W-1:0] LAST_WORD = OFFSET_W'(WORDS_PER_BLOCK - 1);

    state_t              r_state,    w_state_nxt;
    logic [ADDR_W-1:0]   r_addr,     w_addr_nxt;
    logic                r_is_write, w_is_write_nxt;
    logic                r_hit_flag, w_hit_flag_nxt;
    logic [OFFSET_W-1:0] r_cnt,      w_cnt_nxt;

    logic [TAG_W-1:0]    w_req_tag;
    logic [INDEX_W-1:0]  w_req_index;
    logic [OFFSET_W-1:0] w_req_offset;
    logic                w_hit_c;

    assign w_req_tag    = r_addr[ADDR_W-1 -: TAG_W];
    assign w_req_index  = r_addr[OFFSET_W +: INDEX_W];
    assign w_req_offset = r_addr[OFFSET_W-1:0];
    assign w_hit_c      = i_valid_in && (i_tag_in == w_req_tag);

    // State and request registers; reset abandons any partial refill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_addr     <= '0;
            r_is_write <= 1'b0;
            r_hit_flag <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_addr     <= w_addr_nxt;
            r_is_write <= w_is_write_nxt;
            r_hit_flag <= w_hit_flag_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_addr_nxt     = r_addr;
        w_is_write_nxt = r_is_write;
        w_hit_flag_nxt = r_hit_flag;
        w_cnt_nxt      = r_cnt;
        o_sel_index    = '0;
        o_word_sel     = '0;
        o_stall        = 1'b0;
        o_done         = 1'b0;
        o_hit          = 1'b0;
        o_cache_we     = 1'b0;
        o_refill_we    = 1'b0;
        o_tag_we       = 1'b0;
        o_mem_rd       = 1'b0;
        o_mem_wr       = 1'b0;

        if (r_state != ST_IDLE) begin
            o_stall     = 1'b1;
            o_sel_index = w_req_index;
            o_word_sel  = w_req_offset;
        end

        case (r_state)
            ST_IDLE: begin
                if (i_mem_write || i_mem_read) begin
                    w_addr_nxt     = i_address;
                    w_is_write_nxt = i_mem_write;
                    w_state_nxt    = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (r_is_write) begin
                    // Write-no-allocate: only update the data array on a hit
                    o_cache_we     = w_hit_c;
                    w_hit_flag_nxt = w_hit_c;
                    w_state_nxt    = ST_WRITE_MEM;
                end else if (w_hit_c) begin
                    w_hit_flag_nxt = 1'b1;
                    w_state_nxt    = ST_RESPOND;
                end else begin
                    w_hit_flag_nxt = 1'b0;
                    w_cnt_nxt      = '0;
                    w_state_nxt    = ST_REFILL;
                end
            end
            ST_REFILL: begin
                o_mem_rd   = 1'b1;
                o_word_sel = r_cnt;
                if (i_mem_ready) begin
                    o_refill_we = 1'b1;
                    w_cnt_nxt   = r_cnt + OFFSET_W'(1);
                    if (r_cnt == LAST_WORD) begin
                        o_tag_we    = 1'b1;
                        w_state_nxt = ST_RESPOND;
                    end
                end
            end
            ST_WRITE_MEM: begin
                o_mem_wr = 1'b1;
                if (i_mem_ready) begin
                    w_state_nxt = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                o_done      = 1'b1;
                o_hit       = r_hit_flag;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
